// File: rtl/bridge_router.sv
// Bridge router: registered decode of host bridge transactions onto NUM_LEAVES leaf ports,
// with read response tracking, timeout, optional relative addressing/byte-swap and sticky errors.
module bridge_router #(
   parameter int                                         NUM_LEAVES   = 5,
   parameter int                                         ADDR_WIDTH   = 32,
   parameter int                                         DATA_WIDTH   = 32,
   parameter logic [NUM_LEAVES-1:0][2*ADDR_WIDTH-1:0]    ADDR_RANGES  = '0,
   parameter bit                                         RELATIVE     = 1'b0,
   parameter bit                                         SWAP_BYTES   = 1'b0,
   parameter int                                         TIMEOUT      = 255,
   parameter logic [DATA_WIDTH-1:0]                      DEFAULT_DATA = 32'hDEAD_BEEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [ADDR_WIDTH-1:0]              m_addr,
   input  logic                               m_wr,
   input  logic [DATA_WIDTH-1:0]              m_wr_data,
   input  logic                               m_rd,
   output logic [DATA_WIDTH-1:0]              m_rd_data,
   output logic                               m_rd_valid,
   output logic [NUM_LEAVES*ADDR_WIDTH-1:0]   l_addr,
   output logic [NUM_LEAVES-1:0]              l_wr,
   output logic [DATA_WIDTH-1:0]              l_wr_data,
   output logic [NUM_LEAVES-1:0]              l_rd,
   input  logic [NUM_LEAVES*DATA_WIDTH-1:0]   l_rd_data,
   input  logic [NUM_LEAVES-1:0]              l_rd_valid,
   input  logic                               err_clear,
   output logic                               err_unmapped,
   output logic                               err_timeout,
   output logic                               err_overrun,
   output logic                               busy
);

   localparam int SEL_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int NB    = DATA_WIDTH / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   function automatic logic [DATA_WIDTH-1:0] swap_bytes(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++) r[8*b +: 8] = d[DATA_WIDTH-8-8*b +: 8];
      return r;
   endfunction

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] lo,
                                     input logic [ADDR_WIDTH-1:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

   logic                            hit;
   logic [SEL_W-1:0]                hit_idx;
   logic [ADDR_WIDTH-1:0]           hit_base;
   logic                            busy_w, rd_acc, wr_fwd, rd_fwd;
   logic                            set_unm, set_ovr, set_to;
   logic                            leaf_valid;
   logic [DATA_WIDTH-1:0]           leaf_data, resp_data;

   logic [NUM_LEAVES*ADDR_WIDTH-1:0] l_addr_q, l_addr_d;
   logic [DATA_WIDTH-1:0]            l_wr_data_q, l_wr_data_d;
   logic [NUM_LEAVES-1:0]            l_wr_q, l_wr_d, l_rd_q, l_rd_d;
   logic                             rd_req_q, rd_req_d, rd_mapped_q, rd_mapped_d;
   logic [SEL_W-1:0]                 sel_q, sel_d;
   logic [1:0]                       state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]            rd_data_q, rd_data_d;
   logic                             err_unm_q, err_unm_d, err_to_q, err_to_d, err_ovr_q, err_ovr_d;

   // Descending scan so the lowest-indexed matching range wins on overlap.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_base = '0;
      for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
         if (in_range(m_addr, ADDR_RANGES[i][2*ADDR_WIDTH-1:ADDR_WIDTH], ADDR_RANGES[i][ADDR_WIDTH-1:0])) begin
            hit      = 1'b1;
            hit_idx  = SEL_W'(i);
            hit_base = ADDR_RANGES[i][2*ADDR_WIDTH-1:ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      busy_w      = rd_req_q | (state_q != S_IDLE);
      rd_acc      = m_rd & ~busy_w;
      wr_fwd      = m_wr & hit;
      rd_fwd      = rd_acc & hit;
      l_addr_d    = l_addr_q;
      if (wr_fwd | rd_fwd)
         l_addr_d[int'(hit_idx)*ADDR_WIDTH +: ADDR_WIDTH] = RELATIVE ? (m_addr - hit_base) : m_addr;
      l_wr_data_d = l_wr_data_q;
      if (wr_fwd) l_wr_data_d = SWAP_BYTES ? swap_bytes(m_wr_data) : m_wr_data;
      l_wr_d = '0;
      l_rd_d = '0;
      if (wr_fwd) l_wr_d[hit_idx] = 1'b1;
      if (rd_fwd) l_rd_d[hit_idx] = 1'b1;
      rd_req_d    = rd_acc;
      rd_mapped_d = rd_acc ? hit : rd_mapped_q;
      sel_d       = rd_acc ? hit_idx : sel_q;
      set_unm     = (m_wr & ~hit) | (rd_acc & ~hit);
      set_ovr     = m_rd & busy_w;
   end

   // The cycle the leaf strobe is out already counts as a chance for the leaf to answer.
   always_comb begin
      leaf_valid = l_rd_valid[sel_q];
      leaf_data  = l_rd_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
      resp_data  = SWAP_BYTES ? swap_bytes(leaf_data) : leaf_data;
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      set_to     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_req_q) begin
               if (!rd_mapped_q) begin
                  state_d   = S_RESP;
                  rd_data_d = DEFAULT_DATA;
               end else if (leaf_valid) begin
                  state_d   = S_RESP;
                  rd_data_d = resp_data;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
         end
         S_WAIT: begin
            if (leaf_valid) begin
               state_d   = S_RESP;
               rd_data_d = resp_data;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d   = S_RESP;
               rd_data_d = DEFAULT_DATA;
               set_to    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      err_unm_d = (err_unm_q & ~err_clear) | set_unm;
      err_to_d  = (err_to_q  & ~err_clear) | set_to;
      err_ovr_d = (err_ovr_q & ~err_clear) | set_ovr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_addr_q    <= '0;
         l_wr_data_q <= '0;
         l_wr_q      <= '0;
         l_rd_q      <= '0;
         rd_req_q    <= 1'b0;
         rd_mapped_q <= 1'b0;
         sel_q       <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rd_data_q   <= '0;
         err_unm_q   <= 1'b0;
         err_to_q    <= 1'b0;
         err_ovr_q   <= 1'b0;
      end else begin
         l_addr_q    <= l_addr_d;
         l_wr_data_q <= l_wr_data_d;
         l_wr_q      <= l_wr_d;
         l_rd_q      <= l_rd_d;
         rd_req_q    <= rd_req_d;
         rd_mapped_q <= rd_mapped_d;
         sel_q       <= sel_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_data_q   <= rd_data_d;
         err_unm_q   <= err_unm_d;
         err_to_q    <= err_to_d;
         err_ovr_q   <= err_ovr_d;
      end
   end

   assign l_addr       = l_addr_q;
   assign l_wr_data    = l_wr_data_q;
   assign l_wr         = l_wr_q;
   assign l_rd         = l_rd_q;
   assign m_rd_data    = rd_data_q;
   assign m_rd_valid   = (state_q == S_RESP);
   assign busy         = busy_w;
   assign err_unmapped = err_unm_q;
   assign err_timeout  = err_to_q;
   assign err_overrun  = err_ovr_q;

endmodule

// File: tb/tb_bridge_router.sv
// Bench for bridge_router: two instances (raw/unswapped and relative/swapped) driven in parallel,
// checked against a range-table and latency-rule model of the router.
module tb_bridge_router;

   localparam int NL = 5;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [31:0] DEF = 32'hDEAD_BEEF;
   localparam logic [NL-1:0][2*AW-1:0] RANGES = {
      {32'h1000_0000, 32'h1FFF_FFFF},
      {32'h0000_0000, 32'h0FFF_FFFF},
      {32'hF800_0800, 32'hF800_0FFF},
      {32'hF800_2000, 32'hF800_2FFF},
      {32'hF800_0000, 32'hF800_0FFF}};

   logic [31:0] lo [NL] = '{32'hF800_0000, 32'hF800_2000, 32'hF800_0800, 32'h0000_0000, 32'h1000_0000};
   logic [31:0] hi [NL] = '{32'hF800_0FFF, 32'hF800_2FFF, 32'hF800_0FFF, 32'h0FFF_FFFF, 32'h1FFF_FFFF};

   logic clk = 1'b0;
   logic reset;
   logic [AW-1:0] m_addr;
   logic m_wr, m_rd, err_clear;
   logic [DW-1:0] m_wr_data;
   logic [NL*DW-1:0] l_rd_data;
   logic [NL-1:0] l_rd_valid;

   logic [DW-1:0] a_m_rd_data, b_m_rd_data, a_l_wr_data, b_l_wr_data;
   logic a_m_rd_valid, b_m_rd_valid, a_busy, b_busy;
   logic [NL*AW-1:0] a_l_addr, b_l_addr;
   logic [NL-1:0] a_l_wr, b_l_wr, a_l_rd, b_l_rd;
   logic a_err_unm, b_err_unm, a_err_to, b_err_to, a_err_ovr, b_err_ovr;

   int total = 0;
   int bad = 0;
   bit exp_unm, exp_to, exp_ovr;

   always #5 clk = ~clk;

   bridge_router #(.NUM_LEAVES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_RANGES(RANGES),
                   .RELATIVE(1'b0), .SWAP_BYTES(1'b0), .TIMEOUT(TO), .DEFAULT_DATA(DEF)) dut_a (
      .clk(clk), .reset(reset), .m_addr(m_addr), .m_wr(m_wr), .m_wr_data(m_wr_data), .m_rd(m_rd),
      .m_rd_data(a_m_rd_data), .m_rd_valid(a_m_rd_valid), .l_addr(a_l_addr), .l_wr(a_l_wr),
      .l_wr_data(a_l_wr_data), .l_rd(a_l_rd), .l_rd_data(l_rd_data), .l_rd_valid(l_rd_valid),
      .err_clear(err_clear), .err_unmapped(a_err_unm), .err_timeout(a_err_to),
      .err_overrun(a_err_ovr), .busy(a_busy));

   bridge_router #(.NUM_LEAVES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_RANGES(RANGES),
                   .RELATIVE(1'b1), .SWAP_BYTES(1'b1), .TIMEOUT(TO), .DEFAULT_DATA(DEF)) dut_b (
      .clk(clk), .reset(reset), .m_addr(m_addr), .m_wr(m_wr), .m_wr_data(m_wr_data), .m_rd(m_rd),
      .m_rd_data(b_m_rd_data), .m_rd_valid(b_m_rd_valid), .l_addr(b_l_addr), .l_wr(b_l_wr),
      .l_wr_data(b_l_wr_data), .l_rd(b_l_rd), .l_rd_data(l_rd_data), .l_rd_valid(l_rd_valid),
      .err_clear(err_clear), .err_unmapped(b_err_unm), .err_timeout(b_err_to),
      .err_overrun(b_err_ovr), .busy(b_busy));

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NL; i++) if (a >= lo[i] && a <= hi[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] d);
      logic [31:0] r;
      r = {<<8{d}};
      return r;
   endfunction

   function automatic logic [31:0] rand_addr();
      int c;
      c = $urandom_range(0, 5);
      if (c < NL) return lo[c] + ($urandom % (hi[c] - lo[c] + 32'd1));
      return 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_errs();
      check("a_err_unmapped", a_err_unm, exp_unm);
      check("b_err_unmapped", b_err_unm, exp_unm);
      check("a_err_timeout", a_err_to, exp_to);
      check("b_err_timeout", b_err_to, exp_to);
      check("a_err_overrun", a_err_ovr, exp_ovr);
      check("b_err_overrun", b_err_ovr, exp_ovr);
   endtask

   task automatic clear_errs();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      exp_unm = 1'b0;
      exp_to  = 1'b0;
      exp_ovr = 1'b0;
      check_errs();
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      int idx;
      idx = decode(addr);
      m_addr = addr;
      m_wr_data = data;
      m_wr = 1'b1;
      tick();
      m_wr = 1'b0;
      if (idx < 0) begin
         check("wr_unmapped_strobe_a", a_l_wr, 0);
         check("wr_unmapped_strobe_b", b_l_wr, 0);
         exp_unm = 1'b1;
      end else begin
         check("wr_strobe_a", a_l_wr, 1 << idx);
         check("wr_strobe_b", b_l_wr, 1 << idx);
         check("wr_data_a", a_l_wr_data, data);
         check("wr_data_b", b_l_wr_data, bswap(data));
         check("wr_addr_a", a_l_addr[idx*AW +: AW], addr);
         check("wr_addr_b", b_l_addr[idx*AW +: AW], addr - lo[idx]);
      end
      check("wr_no_rd_strobe", a_l_rd, 0);
      check_errs();
   endtask

   // One read: leaf idx answers at cycle N+delay; response timing follows the latency rules.
   task automatic run_read(input logic [31:0] addr, input int delay, input logic [31:0] data,
                           input bit ovr, input bit wr);
      int idx, exp_cyc, t_end, noise;
      logic [31:0] ea, eb, od;
      idx = decode(addr);
      if (idx < 0) begin
         exp_cyc = 2; ea = DEF; eb = DEF;
      end else if (delay <= TO + 2) begin
         exp_cyc = delay + 1; ea = data; eb = bswap(data);
      end else begin
         exp_cyc = TO + 3; ea = DEF; eb = DEF;
      end
      t_end = ((delay > exp_cyc) ? delay : exp_cyc) + 1;
      noise = (idx < 0) ? 0 : (idx + 1) % NL;
      for (int i = 0; i < NL; i++) l_rd_data[i*DW +: DW] = $urandom;
      if (idx >= 0) l_rd_data[idx*DW +: DW] = data;
      od = $urandom;
      m_addr = addr;
      m_rd = 1'b1;
      m_wr = wr;
      m_wr_data = ~data;
      for (int t = 1; t <= t_end; t++) begin
         tick();
         if (t == 1) begin
            check("rd_strobe_a", a_l_rd, (idx < 0) ? 0 : (1 << idx));
            check("rd_strobe_b", b_l_rd, (idx < 0) ? 0 : (1 << idx));
            if (idx >= 0) begin
               check("rd_addr_a", a_l_addr[idx*AW +: AW], addr);
               check("rd_addr_b", b_l_addr[idx*AW +: AW], addr - lo[idx]);
            end
            if (wr) check("rdwr_wr_strobe_a", a_l_wr, (idx < 0) ? 0 : (1 << idx));
         end
         if (t == 2 && ovr) begin
            check("overrun_no_rd_a", a_l_rd, 0);
            check("overrun_no_rd_b", b_l_rd, 0);
            check("overrun_wr_strobe", a_l_wr, 5'b00010);
            check("overrun_wr_data", a_l_wr_data, od);
         end
         check("rd_valid_a", a_m_rd_valid, t == exp_cyc);
         check("rd_valid_b", b_m_rd_valid, t == exp_cyc);
         check("busy_a", a_busy, t <= exp_cyc);
         if (t == exp_cyc) begin
            check("rd_data_a", a_m_rd_data, ea);
            check("rd_data_b", b_m_rd_data, eb);
         end
         m_rd = 1'b0;
         m_wr = 1'b0;
         l_rd_valid = '0;
         if (t == 1) l_rd_valid[noise] = 1'b1;
         if (t == 1 && ovr) begin
            m_addr = 32'hF800_2010;
            m_rd = 1'b1;
            m_wr = 1'b1;
            m_wr_data = od;
         end
         if (t == delay && idx >= 0) l_rd_valid[idx] = 1'b1;
      end
      l_rd_valid = '0;
      if (idx < 0) exp_unm = 1'b1;
      if (idx >= 0 && delay > TO + 2) exp_to = 1'b1;
      if (ovr) exp_ovr = 1'b1;
      check_errs();
   endtask

   initial begin
      reset = 1'b1;
      m_addr = '0; m_wr = 1'b0; m_rd = 1'b0; m_wr_data = '0; err_clear = 1'b0;
      l_rd_data = '0; l_rd_valid = '0;
      exp_unm = 1'b0; exp_to = 1'b0; exp_ovr = 1'b0;
      tick();
      tick();
      check("reset_l_addr", a_l_addr, 0);
      check("reset_l_wr_data", a_l_wr_data, 0);
      check("reset_m_rd_data", a_m_rd_data, 0);
      check("reset_strobes", {a_l_wr, a_l_rd, a_m_rd_valid, a_busy}, 0);
      check_errs();
      reset = 1'b0;
      tick();

      do_write(32'hF800_2004, 32'h1234_5678);
      run_read(32'h0000_0100, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
      run_read(32'h3000_0000, 1, 32'h0, 1'b0, 1'b0);
      clear_errs();
      run_read(32'h0000_0100, 20, 32'h1111_2222, 1'b0, 1'b0);
      clear_errs();
      run_read(32'h1000_0040, 5, 32'hA5A5_0F0F, 1'b1, 1'b0);
      run_read(32'hF800_0900, 1, 32'h0102_0304, 1'b0, 1'b0);
      do_write(32'hF800_0A00, 32'hBEEF_0001);
      run_read(32'hF800_2100, 10, 32'h7777_8888, 1'b0, 1'b1);
      do_write(32'h3000_0004, 32'h5555_AAAA);
      clear_errs();

      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) == 0)
            do_write(rand_addr(), $urandom);
         else
            run_read(rand_addr(), $urandom_range(1, 12), $urandom,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
         if (n % 6 == 5) clear_errs();
      end

      m_addr = 32'h0000_0200;
      m_rd = 1'b1;
      tick();
      tick();
      tick();
      m_rd = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      exp_unm = 1'b0; exp_to = 1'b0; exp_ovr = 1'b0;
      check("midreset_busy", a_busy, 0);
      check("midreset_valid", a_m_rd_valid, 0);
      check("midreset_l_addr", a_l_addr, 0);
      check("midreset_l_wr_data", b_l_wr_data, 0);
      check_errs();
      @(negedge clk);
      reset = 1'b0;
      l_rd_valid[3] = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         l_rd_valid = '0;
         check("after_reset_no_valid_a", a_m_rd_valid, 0);
         check("after_reset_no_valid_b", b_m_rd_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
